func_tt_sweeper: RTL and testbench
==================================

// Module: func_tt_sweeper
// PURPOSE
//  Sequencer for the team's 4-input combinational function blocks (a,b,c,d -> F).
//  On start, drives all 16 input combinations in ascending order into the function block,
//  waits a settle window, and samples F into a 16-bit truth-table register.
//  It also compares the table against an expected mask and reports the mismatch count,
//  the first failing index and a pass flag. Sits between a lab test harness and the DUT function.
// PARAMETERS
//  SETTLE_CYCLES  2  wait cycles between driving a vector and sampling F (legal 0..15)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  start         in   1   request a sweep; accepted only in IDLE
//  expected      in   16  golden truth table, bit k = F for input index k; captured on accept
//  abcd_out      out  4   vector to function block: {a,b,c,d} = abcd_out[3:0], a = MSB
//  f_in          in   1   function block output F
//  busy          out  1   high from cycle after accept until the done cycle (inclusive)
//  done          out  1   one-cycle pulse when the sweep completes
//  truth_table   out  16  sampled F per index
//  mismatch_cnt  out  5   number of indices where truth_table != expected (0..16)
//  first_err     out  4   lowest mismatching index; valid when err_valid
//  err_valid     out  1   at least one mismatch found in current/last sweep
//  pass          out  1   set at done when mismatch_cnt == 0; held until next accept
// BEHAVIOUR
//  Reset (async assert, sync-style release): state=IDLE.
//   - All outputs are 0: abcd_out, busy, done, truth_table, mismatch_cnt, first_err,
//     err_valid and pass.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//   - IDLE: on start=1 at edge T0, latch expected.
//     Clear truth_table, mismatch_cnt, err_valid, first_err and pass.
//     Set idx=0. Go to SETTLE (or SAMPLE if SETTLE_CYCLES==0).
//   - SETTLE: abcd_out=idx. Count SETTLE_CYCLES cycles, then go to SAMPLE.
//   - SAMPLE: abcd_out=idx. Register truth_table[idx] <= f_in.
//     If f_in != exp[idx]: mismatch_cnt += 1; if !err_valid, set first_err=idx and err_valid=1.
//     If idx==15, go to DONE; else idx += 1 and go to SETTLE/SAMPLE.
//   - DONE: done=1 for exactly one cycle. pass = (mismatch_cnt==0), with the final sample included.
//     busy=1 in this cycle only, then IDLE (busy=0).
//  Timing: vector k is driven from cycle T0+1+k*(S+1) and sampled at cycle T0+1+k*(S+1)+S,
//   where S=SETTLE_CYCLES. done is at cycle T0+1+16*(S+1).
//  Handshake and held values:
//   - abcd_out holds its last driven value (15) in IDLE after a sweep; it is 0 after reset.
//   - start while busy or in DONE is ignored: no restart and no queuing.
//   - start held high continuously launches a new sweep in the first IDLE cycle after done.
//  Boundaries:
//   - idx does not wrap; the sweep terminates at idx 15.
//   - mismatch_cnt is 5 bits so that 16 mismatches are representable.
//   - Results stay stable in IDLE until the next accepted start.
//   - Changing expected mid-sweep has no effect; only the copy latched at accept is used.
//   - rst_n low mid-sweep immediately returns all outputs to their reset values.
//     No done pulse is produced.
// TESTING
//  Bench model: F = ~a&~c&d | a&~c&~d | b&~c&d | ~a&~b&c&~d; S=2.
//  1. Reset, then start with expected=16'h3126.
//     Required: truth_table=16'h3126, mismatch_cnt=0, pass=1, err_valid=0,
//     done at exactly T0+49, one-cycle pulse.
//  2. expected=16'h3127 (bit0 wrong).
//     Required: mismatch_cnt=1, first_err=0, err_valid=1, pass=0.
//  3. expected=~16'h3126.
//     Required: mismatch_cnt=16, first_err=0, pass=0.
//  4. Pulse start again at sweep cycle 10, and change expected mid-sweep.
//     Required: no restart, done still at T0+49, results computed against the latched expected.
//  5. Deassert rst_n at sweep cycle 20.
//     Required: all outputs 0 asynchronously, no done; a new start after release completes normally.
//  6. SETTLE_CYCLES=0 build with expected=16'h3126.
//     Required: abcd_out steps 0..15 on consecutive cycles, done at T0+17, pass=1.

Source files
------------

// File: rtl/func_tt_sweeper.sv
// func_tt_sweeper: walks a 4-input combinational function block through all
// 16 input vectors in ascending order. After each vector has settled, F is
// sampled into a truth table. The table is scored against a golden mask that
// is latched when the sweep starts.
//
// Handshake: start is a level request with no ready output. It is accepted
// only on a rising edge where the FSM is in IDLE. While busy is high (which
// includes the done cycle), start is ignored and is not queued. Holding start
// high re-launches a sweep on the first IDLE cycle after done.
module func_tt_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  output logic [3:0]  abcd_out,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_err,
  output logic        err_valid,
  output logic        pass,
  output logic [1:0]  state_dbg_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // With no settle window, every vector goes straight to SAMPLE.
  localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);
  localparam logic [3:0] SETTLE_LAST = NO_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] ST_VECTOR   = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [3:0]  idx_q,   idx_d;
  logic [15:0] exp_q,   exp_d;
  logic [15:0] tt_q,    tt_d;
  logic [4:0]  mis_q,   mis_d;
  logic [3:0]  ferr_q,  ferr_d;
  logic        errv_q,  errv_d;
  logic        pass_q,  pass_d;
  logic        miss;

  // Sampled F disagrees with the latched golden bit for the current vector.
  assign miss = (f_in != exp_q[idx_q]);

  // Next-state and result update logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mis_d   = mis_q;
    ferr_d  = ferr_q;
    errv_d  = errv_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = expected;
          tt_d    = 16'd0;
          mis_d   = 5'd0;
          ferr_d  = 4'd0;
          errv_d  = 1'b0;
          pass_d  = 1'b0;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          state_d = ST_VECTOR;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        tt_d[idx_q] = f_in;
        if (miss) begin
          mis_d = mis_q + 5'd1;
          if (!errv_q) begin
            ferr_d = idx_q;
            errv_d = 1'b1;
          end
        end
        if (idx_q == 4'd15) begin
          // Pass must include the final sample, so do not use mis_q alone.
          pass_d  = !miss && (mis_q == 5'd0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_VECTOR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; async reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      exp_q   <= 16'd0;
      tt_q    <= 16'd0;
      mis_q   <= 5'd0;
      ferr_q  <= 4'd0;
      errv_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
      ferr_q  <= ferr_d;
      errv_q  <= errv_d;
      pass_q  <= pass_d;
    end
  end

  // The vector index drives the function block directly, so it holds 15 after a sweep.
  assign abcd_out     = idx_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign truth_table  = tt_q;
  assign mismatch_cnt = mis_q;
  assign first_err    = ferr_q;
  assign err_valid    = errv_q;
  assign pass         = pass_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_func_tt_sweeper.sv
// Directed bench for func_tt_sweeper. The function block is a behavioural
// model of F, and expected truth tables are hand-computed from F.
// Instance A uses SETTLE_CYCLES=2 and instance B uses SETTLE_CYCLES=0.
module tb_func_tt_sweeper;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (S=2) ----------------
  logic        start_a;
  logic [15:0] expected_a;
  logic [3:0]  abcd_a;
  logic        f_a;
  logic        busy_a, done_a, errv_a, pass_a;
  logic [15:0] tt_a;
  logic [4:0]  mis_a;
  logic [3:0]  ferr_a;
  logic [1:0]  st_a;

  func_tt_sweeper #(.SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
    .abcd_out(abcd_a), .f_in(f_a), .busy(busy_a), .done(done_a),
    .truth_table(tt_a), .mismatch_cnt(mis_a), .first_err(ferr_a),
    .err_valid(errv_a), .pass(pass_a), .state_dbg_o(st_a)
  );

  // ---------------- DUT B (S=0) ----------------
  logic        start_b;
  logic [15:0] expected_b;
  logic [3:0]  abcd_b;
  logic        f_b;
  logic        busy_b, done_b, errv_b, pass_b;
  logic [15:0] tt_b;
  logic [4:0]  mis_b;
  logic [3:0]  ferr_b;
  logic [1:0]  st_b;

  func_tt_sweeper #(.SETTLE_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
    .abcd_out(abcd_b), .f_in(f_b), .busy(busy_b), .done(done_b),
    .truth_table(tt_b), .mismatch_cnt(mis_b), .first_err(ferr_b),
    .err_valid(errv_b), .pass(pass_b), .state_dbg_o(st_b)
  );

  // Function block model: F = ~a~cd | a~c~d | b~cd | ~a~bc~d, a = bit 3.
  function automatic logic f_model(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~a & ~c & d) | (a & ~c & ~d) | (b & ~c & d) | (~a & ~b & c & ~d);
  endfunction

  assign f_a = f_model(abcd_a);
  assign f_b = f_model(abcd_b);

  // ---------------- scoreboard ----------------
  int chk_cnt;
  int err_cnt;
  int t0_a, t0_b;
  int done_cnt_a;
  logic [3:0] exp_q[$];

  always @(negedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns on the negedge just after the accept edge (cyc == t0_a).
  task automatic start_sweep_a(input logic [15:0] e);
    @(negedge clk);
    expected_a = e;
    start_a    = 1'b1;
    t0_a       = cyc + 1;
    @(negedge clk);
    start_a    = 1'b0;
  endtask

  // Waits for done (bounded), checks latency and the one-cycle pulse shape.
  task automatic wait_done_a(input string tag, input int lat);
    int n;
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done_a), 32'd1);
    check({tag, "_lat"}, 32'(cyc + 1 - t0_a), 32'(lat));
    check({tag, "_busy_in_done"}, 32'(busy_a), 32'd1);
  endtask

  task automatic after_done_a(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_a), 32'd0);
    check({tag, "_busy_off"}, 32'(busy_a), 32'd0);
  endtask

  task automatic check_results_a(input string tag, input logic [15:0] tt,
                                 input logic [4:0] mis, input logic [3:0] fe,
                                 input logic ev, input logic ps);
    check({tag, "_tt"}, 32'(tt_a), 32'(tt));
    check({tag, "_mis"}, 32'(mis_a), 32'(mis));
    check({tag, "_errv"}, 32'(errv_a), 32'(ev));
    if (ev) check({tag, "_ferr"}, 32'(ferr_a), 32'(fe));
    check({tag, "_pass"}, 32'(pass_a), 32'(ps));
  endtask

  task automatic check_all_zero_a(input string tag);
    check({tag, "_abcd"}, 32'(abcd_a), 32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_tt"}, 32'(tt_a), 32'd0);
    check({tag, "_mis"}, 32'(mis_a), 32'd0);
    check({tag, "_ferr"}, 32'(ferr_a), 32'd0);
    check({tag, "_errv"}, 32'(errv_a), 32'd0);
    check({tag, "_pass"}, 32'(pass_a), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, n;
    cyc        = 0;
    chk_cnt    = 0;
    err_cnt    = 0;
    done_cnt_a = 0;
    rst_n      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    expected_a = 16'h0;
    expected_b = 16'h0;

    // Reset state
    #3;
    check_all_zero_a("reset");
    check("reset_b_abcd", 32'(abcd_b), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. Golden sweep, plus vector timing around the vector 4/5 boundary
    start_sweep_a(16'h3126);
    check("t1_busy", 32'(busy_a), 32'd1);
    repeat (14) @(negedge clk);
    check("t1_vec4_sample", 32'(abcd_a), 32'd4);
    @(negedge clk);
    check("t1_vec5_drive", 32'(abcd_a), 32'd5);
    wait_done_a("t1", 49);
    check_results_a("t1_at_done", 16'h3126, 5'd0, 4'd0, 1'b0, 1'b1);
    after_done_a("t1");
    repeat (5) @(negedge clk);
    check("t1_idle_abcd_hold", 32'(abcd_a), 32'd15);
    check_results_a("t1_idle_hold", 16'h3126, 5'd0, 4'd0, 1'b0, 1'b1);

    // 2. Bit 0 wrong
    start_sweep_a(16'h3127);
    wait_done_a("t2", 49);
    after_done_a("t2");
    check_results_a("t2", 16'h3126, 5'd1, 4'd0, 1'b1, 1'b0);

    // 3. Every bit wrong
    start_sweep_a(~16'h3126);
    wait_done_a("t3", 49);
    after_done_a("t3");
    check_results_a("t3", 16'h3126, 5'd16, 4'd0, 1'b1, 1'b0);

    // 3b. Only the last index wrong: pass must see the final sample
    start_sweep_a(16'hB126);
    wait_done_a("t3b", 49);
    after_done_a("t3b");
    check_results_a("t3b", 16'h3126, 5'd1, 4'd15, 1'b1, 1'b0);

    // 4. Re-start pulse and expected change mid-sweep are ignored
    start_sweep_a(16'h3126);
    repeat (9) @(negedge clk);
    start_a    = 1'b1;
    expected_a = 16'h0000;
    @(negedge clk);
    start_a    = 1'b0;
    wait_done_a("t4", 49);
    after_done_a("t4");
    check_results_a("t4", 16'h3126, 5'd0, 4'd0, 1'b0, 1'b1);

    // 4b. Start held high relaunches on the first IDLE cycle after done
    @(negedge clk);
    expected_a = 16'h3127;
    start_a    = 1'b1;
    t0_a       = cyc + 1;
    @(negedge clk);
    wait_done_a("t4b_first", 49);
    @(negedge clk);
    check("t4b_idle_gap", 32'(busy_a), 32'd0);
    t0_a = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    check("t4b_relaunch", 32'(busy_a), 32'd1);
    wait_done_a("t4b_second", 49);
    after_done_a("t4b");
    check_results_a("t4b", 16'h3126, 5'd1, 4'd0, 1'b1, 1'b0);

    // 5. Async reset mid-sweep
    start_sweep_a(16'h3127);
    repeat (19) @(negedge clk);
    check("t5_busy_before", 32'(busy_a), 32'd1);
    #2;
    d0    = done_cnt_a;
    rst_n = 1'b0;
    #1;
    check_all_zero_a("t5_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_no_done", 32'(done_cnt_a - d0), 32'd0);
    check_all_zero_a("t5_after");
    start_sweep_a(16'h3126);
    wait_done_a("t5_rerun", 49);
    after_done_a("t5_rerun");
    check_results_a("t5_rerun", 16'h3126, 5'd0, 4'd0, 1'b0, 1'b1);

    // 6. SETTLE_CYCLES=0: one vector per cycle
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
    @(negedge clk);
    expected_b = 16'h3126;
    start_b    = 1'b1;
    t0_b       = cyc + 1;
    @(negedge clk);
    start_b    = 1'b0;
    check("t6_vec_0", 32'(abcd_b), 32'(exp_q.pop_front()));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("t6_vec_step", 32'(abcd_b), 32'(exp_q.pop_front()));
    end
    n = 0;
    while (!done_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_done", 32'(done_b), 32'd1);
    check("t6_lat", 32'(cyc + 1 - t0_b), 32'd17);
    check("t6_tt", 32'(tt_b), 32'h3126);
    check("t6_mis", 32'(mis_b), 32'd0);
    check("t6_pass", 32'(pass_b), 32'd1);
    @(negedge clk);
    check("t6_done_pulse", 32'(done_b), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
